// File: rtl/calc_input_sequencer.sv
// Operand/opcode entry sequencer for the lab calculator: collects two operands
// and an opcode via one enter button, then latches the calculator result.
module calc_input_sequencer #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   sw,
  input  logic [3:0]     op_sw,
  input  logic           btn_enter,
  input  logic           btn_clear,
  input  logic [2*N-1:0] calc_result,
  output logic [N-1:0]   operand1,
  output logic [N-1:0]   operand2,
  output logic [3:0]     op_select,
  output logic [2*N-1:0] result_q,
  output logic           result_valid,
  output logic [2:0]     state_o
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_ent_s1, r_ent_s2, r_ent_s3;
  logic           r_clr_s1, r_clr_s2, r_clr_s3;
  logic [N-1:0]   r_operand1, r_operand2, w_operand1_nxt, w_operand2_nxt;
  logic [3:0]     r_op_select, w_op_select_nxt;
  logic [2*N-1:0] r_result_q, w_result_q_nxt;
  logic           r_result_valid, w_result_valid_nxt;
  logic           w_enter_pulse, w_clear_pulse;

  // Two-flop synchronizers plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent_s1 <= 1'b0;
      r_ent_s2 <= 1'b0;
      r_ent_s3 <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
      r_clr_s3 <= 1'b0;
    end else begin
      r_ent_s1 <= btn_enter;
      r_ent_s2 <= r_ent_s1;
      r_ent_s3 <= r_ent_s2;
      r_clr_s1 <= btn_clear;
      r_clr_s2 <= r_clr_s1;
      r_clr_s3 <= r_clr_s2;
    end
  end

  assign w_enter_pulse = r_ent_s2 & ~r_ent_s3;
  assign w_clear_pulse = r_clr_s2 & ~r_clr_s3;

  always_comb begin
    w_state_nxt        = r_state;
    w_operand1_nxt     = r_operand1;
    w_operand2_nxt     = r_operand2;
    w_op_select_nxt    = r_op_select;
    w_result_q_nxt     = r_result_q;
    w_result_valid_nxt = r_result_valid;
    if (w_clear_pulse) begin
      w_state_nxt        = S_A;
      w_operand1_nxt     = '0;
      w_operand2_nxt     = '0;
      w_op_select_nxt    = '0;
      w_result_q_nxt     = '0;
      w_result_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_A: if (w_enter_pulse) begin
          w_operand1_nxt = sw;
          w_state_nxt    = S_B;
        end
        S_B: if (w_enter_pulse) begin
          w_operand2_nxt = sw;
          w_state_nxt    = S_OP;
        end
        S_OP: if (w_enter_pulse) begin
          w_op_select_nxt = op_sw;
          w_state_nxt     = S_EXEC;
        end
        // One cycle in S_EXEC lets the calculator settle on the new opcode
        S_EXEC: begin
          w_result_q_nxt     = calc_result;
          w_result_valid_nxt = 1'b1;
          w_state_nxt        = S_DONE;
        end
        S_DONE: if (w_enter_pulse) begin
          w_result_valid_nxt = 1'b0;
          w_state_nxt        = S_A;
        end
        default: w_state_nxt = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_A;
      r_operand1     <= '0;
      r_operand2     <= '0;
      r_op_select    <= '0;
      r_result_q     <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_operand1     <= w_operand1_nxt;
      r_operand2     <= w_operand2_nxt;
      r_op_select    <= w_op_select_nxt;
      r_result_q     <= w_result_q_nxt;
      r_result_valid <= w_result_valid_nxt;
    end
  end

  assign operand1     = r_operand1;
  assign operand2     = r_operand2;
  assign op_select    = r_op_select;
  assign result_q     = r_result_q;
  assign result_valid = r_result_valid;
  assign state_o      = r_state;

endmodule
